// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel coordinates, buffers visible pixels in a FIFO and measures timing.
// Optional per-frame pixel checksum output (frame_sum) when VGA_CAPTURE_CHECKSUM_EN is defined.
//
// state  | meaning
// IDLE   | after reset, waiting for the first VS leading edge
// SYNC   | frame started, waiting for the first visible pixel
// ACTIVE | visible region of the frame in progress
module vga_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        capture_en,
    input  logic        clear_ovf,
    input  logic        HS,
    input  logic        VS,
    input  logic        blank_n,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_pixel,
    output logic [10:0] out_h,
    output logic [10:0] out_v,
    output logic [31:0] out_addr,
    output logic        frame_done,
    output logic [10:0] h_total,
    output logic [10:0] h_active,
    output logic [10:0] v_active,
    output logic        locked,
`ifdef VGA_CAPTURE_CHECKSUM_EN
    output logic [31:0] frame_sum,
`endif
    output logic        overflow
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [10:0] SAT     = 11'h7FF;

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    logic        hs_act_r, hs_act_d, vs_act_r, vs_act_d;
    logic        blank_r, cap_en_r, clr_ovf_r;
    logic [23:0] pix_r;
    logic        hs_lead, vs_lead;

    state_t      state, state_nxt;
    logic        frame_evt;
    logic        vis;

    logic [10:0] h, v, hcyc, v_frame;
    logic [31:0] addr;
    logic        line_vis, cap_frame;

    logic [10:0] p_htot, p_hact, p_vact;
    logic        p_valid;

    logic [77:0]   mem [FIFO_DEPTH];
    logic [77:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push_req, push, pop, full, drop;

    // Sync levels are registered as "active" flags so an idle bus after reset never looks like an edge.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_act_r  <= 1'b0;
            hs_act_d  <= 1'b0;
            vs_act_r  <= 1'b0;
            vs_act_d  <= 1'b0;
            blank_r   <= 1'b0;
            cap_en_r  <= 1'b0;
            clr_ovf_r <= 1'b0;
            pix_r     <= '0;
        end else begin
            hs_act_r  <= (HS == HS_POL);
            hs_act_d  <= hs_act_r;
            vs_act_r  <= (VS == VS_POL);
            vs_act_d  <= vs_act_r;
            blank_r   <= blank_n;
            cap_en_r  <= capture_en;
            clr_ovf_r <= clear_ovf;
            pix_r     <= {red, green, blue};
        end
    end

    assign hs_lead = hs_act_r & ~hs_act_d;
    assign vs_lead = vs_act_r & ~vs_act_d;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        frame_evt = 1'b0;
        case (state)
            IDLE:   if (vs_lead) state_nxt = SYNC;
            SYNC:   if (!vs_lead && blank_r) state_nxt = ACTIVE;
            ACTIVE: if (vs_lead) begin
                        state_nxt = SYNC;
                        frame_evt = 1'b1;
                    end
            default: state_nxt = IDLE;
        endcase
    end

    // The first visible pixel is taken while still in SYNC, so it is counted and pushed too.
    assign vis     = blank_r & (state != IDLE);
    assign v_frame = (line_vis && v != SAT) ? v + 11'd1 : v;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h         <= '0;
            v         <= '0;
            addr      <= '0;
            line_vis  <= 1'b0;
            cap_frame <= 1'b0;
            h_active  <= '0;
            v_active  <= '0;
        end else if (vs_lead) begin
            h         <= '0;
            v         <= '0;
            addr      <= '0;
            line_vis  <= 1'b0;
            cap_frame <= cap_en_r;
            v_active  <= v_frame;
        end else begin
            if (hs_lead) begin
                h        <= '0;
                line_vis <= 1'b0;
                if (line_vis) begin
                    h_active <= h;
                    if (v != SAT) v <= v + 11'd1;
                end
            end else if (vis) begin
                if (h != SAT) h <= h + 11'd1;
                line_vis <= 1'b1;
            end
            if (vis) addr <= addr + 32'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hcyc    <= '0;
            h_total <= '0;
        end else if (hs_lead) begin
            h_total <= hcyc;
            hcyc    <= 11'd1;
        end else if (hcyc != SAT) begin
            hcyc <= hcyc + 11'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done <= 1'b0;
            locked     <= 1'b0;
            p_valid    <= 1'b0;
            p_htot     <= '0;
            p_hact     <= '0;
            p_vact     <= '0;
        end else begin
            frame_done <= frame_evt;
            if (frame_evt) begin
                locked  <= p_valid && (h_total == p_htot) && (h_active == p_hact) && (v_frame == p_vact);
                p_valid <= 1'b1;
                p_htot  <= h_total;
                p_hact  <= h_active;
                p_vact  <= v_frame;
            end
        end
    end

    assign push_req = vis & cap_frame;
    assign pop      = out_valid & out_ready;
    assign full     = (count == DEPTH_C);
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge vga_clk) begin
        if (push) mem[wr_ptr] <= {pix_r, h, v, addr};
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop)           overflow <= 1'b1;
            else if (clr_ovf_r) overflow <= 1'b0;
        end
    end

    // Head fields are forced to zero while empty so stale RAM never reaches the outputs.
    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_pixel = out_valid ? head[77:54] : '0;
    assign out_h     = out_valid ? head[53:43] : '0;
    assign out_v     = out_valid ? head[42:32] : '0;
    assign out_addr  = out_valid ? head[31:0]  : '0;

`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [31:0] sum_acc, sum_nxt;

    assign sum_nxt = sum_acc + (vis ? {8'h0, pix_r} : 32'h0);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else begin
            if (frame_evt) frame_sum <= sum_nxt;
            if (vs_lead)   sum_acc   <= '0;
            else           sum_acc   <= sum_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: frame table plus overflow, full-FIFO, reset and checksum sequences.
module tb_vga_capture;

    logic        vga_clk = 1'b0;
    logic        reset_n, capture_en, clear_ovf, HS, VS, blank_n, out_ready;
    logic [7:0]  red, green, blue;
    logic        out_valid, frame_done, locked, overflow;
    logic [23:0] out_pixel;
    logic [10:0] out_h, out_v, h_total, h_active, v_active;
    logic [31:0] out_addr;
`ifdef VGA_CAPTURE_CHECKSUM_EN
    logic [31:0] frame_sum;
`endif

    always #5 vga_clk = ~vga_clk;

    vga_capture #(.FIFO_DEPTH(16), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .capture_en(capture_en), .clear_ovf(clear_ovf),
        .HS(HS), .VS(VS), .blank_n(blank_n), .red(red), .green(green), .blue(blue),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_h(out_h), .out_v(out_v), .out_addr(out_addr), .frame_done(frame_done),
        .h_total(h_total), .h_active(h_active), .v_active(v_active), .locked(locked),
`ifdef VGA_CAPTURE_CHECKSUM_EN
        .frame_sum(frame_sum),
`endif
        .overflow(overflow)
    );

    typedef struct packed {
        logic [23:0] pix;
        logic [10:0] h;
        logic [10:0] v;
        logic [31:0] addr;
    } word_t;

    typedef struct {
        int nlines;
        int nvis;
        bit cap;
        int words;
        int htot;
        int hact;
        int vact;
        bit lck;
    } vec_t;

    word_t q[$];
    int    fd_cnt = 0;
    int    total  = 0;
    int    bad    = 0;

    always @(negedge vga_clk) begin
        if (out_valid && out_ready) q.push_back({out_pixel, out_h, out_v, out_addr});
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic word_t exp_word(input int j, input int nvis);
        word_t w;
        w.addr = 32'(j);
        w.h    = 11'(j % nvis);
        w.v    = 11'(j / nvis);
        w.pix  = {8'(j / nvis), 8'(j % nvis), 8'h5A};
        return w;
    endfunction

    task automatic chk_words(input string tag, input int base, input int n, input int nvis);
        chk($sformatf("%s_count", tag), 80'(q.size() - base), 80'(n));
        for (int j = 0; j < n && base + j < q.size(); j++)
            chk($sformatf("%s_word%0d", tag, j), 80'(q[base + j]), 80'(exp_word(j, nvis)));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    // 12-cycle line: HS active c0-c1, back porch c2, visible from c3; VS changes mid-line at c5.
    task automatic drive_line(input int nvis, input int ln, input bit vs_on, input bit use_const,
                              input int ready_col);
        for (int c = 0; c < 12; c++) begin
            HS = (c < 2) ? 1'b0 : 1'b1;
            if (c == 5) VS = vs_on ? 1'b0 : 1'b1;
            if (c >= 3 && c < 3 + nvis) begin
                blank_n = 1'b1;
                if (use_const) {red, green, blue} = 24'h000001;
                else begin
                    red   = 8'(ln);
                    green = 8'(c - 3);
                    blue  = 8'h5A;
                end
            end else begin
                blank_n = 1'b0;
                {red, green, blue} = 24'h0;
            end
            if (ready_col >= 0 && c == 3 + ready_col) out_ready = 1'b1;
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic vs_line();
        drive_line(0, 0, 1'b1, 1'b0, -1);
    endtask

    task automatic frame_body(input int nlines, input int nvis, input bit use_const,
                              input int ready_line, input int ready_col);
        drive_line(0, 0, 1'b0, 1'b0, -1);
        for (int ln = 0; ln < nlines; ln++)
            drive_line(nvis, ln, 1'b0, use_const, (ln == ready_line) ? ready_col : -1);
        drive_line(0, 0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        vec_t vecs[6];
        int   qb, fdb;

        vecs[0] = '{4, 8, 1'b1, 32, 12, 8, 4, 1'b0};
        vecs[1] = '{4, 8, 1'b1, 32, 12, 8, 4, 1'b1};
        vecs[2] = '{4, 7, 1'b1, 28, 12, 7, 4, 1'b0};
        vecs[3] = '{4, 7, 1'b1, 28, 12, 7, 4, 1'b1};
        vecs[4] = '{3, 7, 1'b0,  0, 12, 7, 3, 1'b0};
        vecs[5] = '{3, 7, 1'b1, 21, 12, 7, 3, 1'b1};

        reset_n = 1'b0; capture_en = 1'b1; clear_ovf = 1'b0; out_ready = 1'b1;
        HS = 1'b1; VS = 1'b1; blank_n = 1'b0; {red, green, blue} = 24'h0;
        cycles(3);
        chk("rst_valid",    80'(out_valid),  80'(0));
        chk("rst_addr",     80'(out_addr),   80'(0));
        chk("rst_h_total",  80'(h_total),    80'(0));
        chk("rst_locked",   80'(locked),     80'(0));
        chk("rst_overflow", 80'(overflow),   80'(0));
        chk("rst_fd",       80'(frame_done), 80'(0));
        reset_n = 1'b1;
        cycles(1);

        capture_en = vecs[0].cap;
        fdb = fd_cnt;
        vs_line();
        chk("idle_exit_fd", 80'(fd_cnt - fdb), 80'(0));

        for (int i = 0; i < 6; i++) begin
            qb  = q.size();
            fdb = fd_cnt;
            out_ready = 1'b1;
            frame_body(vecs[i].nlines, vecs[i].nvis, 1'b0, -1, -1);
            capture_en = (i < 5) ? vecs[i + 1].cap : 1'b1;
            vs_line();
            chk($sformatf("v%0d_fd", i),       80'(fd_cnt - fdb), 80'(1));
            chk_words($sformatf("v%0d", i), qb, vecs[i].words, vecs[i].nvis);
            chk($sformatf("v%0d_h_total", i),  80'(h_total),  80'(vecs[i].htot));
            chk($sformatf("v%0d_h_active", i), 80'(h_active), 80'(vecs[i].hact));
            chk($sformatf("v%0d_v_active", i), 80'(v_active), 80'(vecs[i].vact));
            chk($sformatf("v%0d_locked", i),   80'(locked),   80'(vecs[i].lck));
            chk($sformatf("v%0d_overflow", i), 80'(overflow), 80'(0));
        end

        // Stalled consumer: first 16 pixels kept, the rest dropped.
        out_ready = 1'b0;
        qb = q.size();
        frame_body(4, 8, 1'b0, -1, -1);
        vs_line();
        chk("ovf_popped",   80'(q.size() - qb), 80'(0));
        chk("ovf_valid",    80'(out_valid),     80'(1));
        chk("ovf_flag",     80'(overflow),      80'(1));
        chk("ovf_head",     80'(out_addr),      80'(0));
        clear_ovf = 1'b1;
        cycles(1);
        clear_ovf = 1'b0;
        cycles(2);
        chk("ovf_cleared",  80'(overflow),      80'(0));
        out_ready = 1'b1;
        cycles(20);
        chk_words("ovf_drain", qb, 16, 8);

        // FIFO fills on two lines, then push and pop coincide while full.
        out_ready = 1'b0;
        qb = q.size();
        frame_body(4, 8, 1'b0, 2, 1);
        vs_line();
        chk_words("full", qb, 32, 8);
        chk("full_overflow", 80'(overflow), 80'(0));
        chk("full_locked",   80'(locked),   80'(1));

        // Asynchronous reset in the middle of a frame.
        out_ready = 1'b0;
        qb = q.size();
        drive_line(0, 0, 1'b0, 1'b0, -1);
        drive_line(8, 0, 1'b0, 1'b0, -1);
        chk("pre_rst_valid", 80'(out_valid), 80'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid",    80'(out_valid), 80'(0));
        chk("arst_h_total",  80'(h_total),   80'(0));
        chk("arst_h_active", 80'(h_active),  80'(0));
        chk("arst_v_active", 80'(v_active),  80'(0));
        chk("arst_locked",   80'(locked),    80'(0));
        @(posedge vga_clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        fdb = fd_cnt;
        drive_line(8, 1, 1'b0, 1'b0, -1);
        drive_line(8, 2, 1'b0, 1'b0, -1);
        drive_line(0, 0, 1'b0, 1'b0, -1);
        chk("idle_nopush", 80'(q.size() - qb), 80'(0));
        chk("idle_valid",  80'(out_valid),     80'(0));
        vs_line();
        chk("idle_fd",     80'(fd_cnt - fdb),  80'(0));
        frame_body(2, 8, 1'b0, -1, -1);
        vs_line();
        chk("post_rst_fd", 80'(fd_cnt - fdb),  80'(1));
        chk_words("post_rst", qb, 16, 8);
        chk("post_rst_v_active", 80'(v_active), 80'(2));

`ifdef VGA_CAPTURE_CHECKSUM_EN
        frame_body(4, 8, 1'b1, -1, -1);
        vs_line();
        chk("frame_sum", 80'(frame_sum), 80'(32));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
